// File: rtl/segway_pkg.sv
// Shared battery-monitor types and default thresholds for the segway top level.
package segway_pkg;

   typedef enum logic [1:0] {
      PRIME = 2'd0,
      OK    = 2'd1,
      LOW   = 2'd2,
      CRIT  = 2'd3
   } batt_state_t;

   localparam logic [11:0] BATT_LOW_THRES  = 12'h800;
   localparam logic [11:0] BATT_LOW_CLR    = 12'h840;
   localparam logic [11:0] BATT_CRIT_THRES = 12'h700;

endpackage

// File: rtl/batt_avg.sv
// Block averager: sums 2^FILT_SHIFT battery conversions and publishes the truncated mean.
module batt_avg #(
   parameter int unsigned FILT_SHIFT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        batt_vld,
   input  logic [11:0] batt,
   output logic [11:0] new_avg,
   output logic        avg_done,
   output logic [11:0] batt_avg,
   output logic        avg_vld
);

   localparam int unsigned ACC_W = 12 + FILT_SHIFT;
   // A 1-bit counter pinned at zero stands in for the zero-width case (FILT_SHIFT = 0).
   localparam int unsigned CNT_W = (FILT_SHIFT == 0) ? 1 : FILT_SHIFT;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << FILT_SHIFT) - 1);

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [11:0]      batt_avg_q, batt_avg_d;
   logic             avg_vld_q, avg_vld_d;

   assign sum      = acc_q + ACC_W'(batt);
   assign new_avg  = 12'(sum >> FILT_SHIFT);
   assign avg_done = batt_vld && (smp_cnt_q == CNT_LAST);

   always_comb begin
      acc_d      = acc_q;
      smp_cnt_d  = smp_cnt_q;
      batt_avg_d = batt_avg_q;
      avg_vld_d  = 1'b0;
      if (avg_done) begin
         acc_d      = '0;
         smp_cnt_d  = '0;
         batt_avg_d = new_avg;
         avg_vld_d  = 1'b1;
      end else if (batt_vld) begin
         acc_d     = sum;
         smp_cnt_d = smp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         smp_cnt_q  <= '0;
         batt_avg_q <= '0;
         avg_vld_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         smp_cnt_q  <= smp_cnt_d;
         batt_avg_q <= batt_avg_d;
         avg_vld_q  <= avg_vld_d;
      end
   end

   assign batt_avg = batt_avg_q;
   assign avg_vld  = avg_vld_q;

endmodule

// File: rtl/batt_mon.sv
// Battery monitor: averaged reading classified into low/critical levels.
// Define BATT_HYST_EN to make LOW -> OK require the average to reach LOW_CLR.
module batt_mon
   import segway_pkg::*;
#(
   parameter int unsigned FILT_SHIFT = 3,
   parameter logic [11:0] LOW_THRES  = BATT_LOW_THRES,
   parameter logic [11:0] LOW_CLR    = BATT_LOW_CLR,
   parameter logic [11:0] CRIT_THRES = BATT_CRIT_THRES,
   parameter int unsigned CRIT_CNT   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        batt_vld,
   input  logic [11:0] batt,
   output logic [11:0] batt_avg,
   output logic        avg_vld,
   output logic        batt_low,
   output logic        batt_crit
);

`ifdef BATT_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif
   localparam logic [11:0] CLR_LVL  = HYST ? LOW_CLR : LOW_THRES;
   localparam logic [3:0]  CRIT_LIM = 4'(CRIT_CNT);

   logic [11:0] new_avg;
   logic        avg_done;
   logic        below_crit;
   logic [3:0]  crit_cnt_q, crit_cnt_d, crit_inc;
   batt_state_t state_q, state_d;

   batt_avg #(
      .FILT_SHIFT(FILT_SHIFT)
   ) u_avg (
      .clk      (clk),
      .rst_n    (rst_n),
      .batt_vld (batt_vld),
      .batt     (batt),
      .new_avg  (new_avg),
      .avg_done (avg_done),
      .batt_avg (batt_avg),
      .avg_vld  (avg_vld)
   );

   assign below_crit = (new_avg < CRIT_THRES);
   assign crit_inc   = (crit_cnt_q >= CRIT_LIM) ? crit_cnt_q : crit_cnt_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      crit_cnt_d = crit_cnt_q;
      if (avg_done && (state_q != CRIT)) begin
         crit_cnt_d = below_crit ? crit_inc : '0;
         if (below_crit && (crit_inc == CRIT_LIM)) begin
            state_d = CRIT;
         end else begin
            case (state_q)
               PRIME:   state_d = (new_avg >= LOW_THRES) ? OK : LOW;
               OK:      if (new_avg < LOW_THRES) state_d = LOW;
               LOW:     if (new_avg >= CLR_LVL)  state_d = OK;
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PRIME;
         crit_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         crit_cnt_q <= crit_cnt_d;
      end
   end

   assign batt_low  = (state_q == LOW) || (state_q == CRIT);
   assign batt_crit = (state_q == CRIT);

endmodule

// File: tb/tb_batt_mon.sv
// Directed table-driven bench for batt_mon at default parameters.
module tb_batt_mon;

`ifdef BATT_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        batt_vld = 1'b0;
   logic [11:0] batt = '0;
   logic [11:0] batt_avg;
   logic        avg_vld;
   logic        batt_low;
   logic        batt_crit;

   int n_vec = 0;
   int n_err = 0;

   batt_mon dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .batt_vld  (batt_vld),
      .batt      (batt),
      .batt_avg  (batt_avg),
      .avg_vld   (avg_vld),
      .batt_low  (batt_low),
      .batt_crit (batt_crit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] s0;
      logic [11:0] s1;
      int          gap;
      logic [11:0] ea;
      logic        el;
      logic        ec;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Eight strobes: first four carry s0, last four s1; gap idle cycles between strobes.
   task automatic run_block(input string tag, input logic [11:0] s0, input logic [11:0] s1,
                            input int gap, input logic [11:0] ea, input logic el, input logic ec);
      int   pulses;
      logic v8;
      pulses = 0;
      v8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         batt_vld = 1'b1;
         batt     = (i < 4) ? s0 : s1;
         @(posedge clk);
         #1;
         batt_vld = 1'b0;
         if (i < 7) begin
            pulses += int'(avg_vld);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk);
               #1;
               pulses += int'(avg_vld);
            end
         end else begin
            v8 = avg_vld;
         end
      end
      chk({tag, " early_pulse"}, 12'(pulses), 12'd0);
      chk({tag, " avg_vld"},     12'(v8),     12'd1);
      chk({tag, " batt_avg"},    batt_avg,    ea);
      chk({tag, " batt_low"},    12'(batt_low),  12'(el));
      chk({tag, " batt_crit"},   12'(batt_crit), 12'(ec));
      @(posedge clk);
      #1;
      chk({tag, " vld_one_cycle"}, 12'(avg_vld), 12'd0);
   endtask

   initial begin
      vecs[0]  = '{12'hA00, 12'hA00, 0, 12'hA00, 1'b0, 1'b0};
      vecs[1]  = '{12'h7F0, 12'h7F0, 1, 12'h7F0, 1'b1, 1'b0};
      vecs[2]  = '{12'h820, 12'h820, 0, 12'h820, HYST, 1'b0};
      vecs[3]  = '{12'h840, 12'h840, 2, 12'h840, 1'b0, 1'b0};
      vecs[4]  = '{12'h800, 12'h7F8, 0, 12'h7FC, 1'b1, 1'b0};
      vecs[5]  = '{12'h840, 12'h840, 0, 12'h840, 1'b0, 1'b0};
      vecs[6]  = '{12'h800, 12'h800, 0, 12'h800, 1'b0, 1'b0};
      vecs[7]  = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b0};
      vecs[8]  = '{12'h6F0, 12'h6F0, 1, 12'h6F0, 1'b1, 1'b0};
      vecs[9]  = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b0};
      vecs[10] = '{12'h780, 12'h780, 0, 12'h780, 1'b1, 1'b0};
      vecs[11] = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b0};
      vecs[12] = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b0};
      vecs[13] = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b0};
      vecs[14] = '{12'h6F0, 12'h6F0, 0, 12'h6F0, 1'b1, 1'b1};
      vecs[15] = '{12'hFFF, 12'hFFF, 0, 12'hFFF, 1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst batt_avg",  batt_avg,        12'h000);
      chk("rst avg_vld",   12'(avg_vld),    12'd0);
      chk("rst batt_low",  12'(batt_low),   12'd0);
      chk("rst batt_crit", 12'(batt_crit),  12'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 16; v++) begin
         run_block($sformatf("vec%0d", v), vecs[v].s0, vecs[v].s1, vecs[v].gap,
                   vecs[v].ea, vecs[v].el, vecs[v].ec);
      end

      // Partial block of 0x100 must be discarded by an asynchronous reset.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         batt_vld = 1'b1;
         batt     = 12'h100;
         @(posedge clk);
         #1;
         batt_vld = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("inrst batt_avg",  batt_avg,       12'h000);
      chk("inrst avg_vld",   12'(avg_vld),   12'd0);
      chk("inrst batt_low",  12'(batt_low),  12'd0);
      chk("inrst batt_crit", 12'(batt_crit), 12'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_block("post_rst", 12'h900, 12'h900, 0, 12'h900, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
